eqed_sig_checker: RTL



---
 rtl/eqed_chk_pkg.sv | 37 +++
 rtl/eqed_misr.sv | 57 +++++
 rtl/eqed_sig_checker.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/eqed_chk_pkg.sv
// eqed_chk_pkg: shared definitions for the EQED response-side signature checker.
//   - state_e      : checker FSM states (IDLE, RUN, DONE)
//   - DEF_SIG_W    : default MISR width
//   - DEF_POLY     : default MISR feedback tap mask
//   - DEF_SEED     : default MISR seed value
//   - misr_next()  : one MISR step. din must already be zero-extended to the
//                    MISR width. Operands are sized to DEF_SIG_W.
package eqed_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int                   DEF_SIG_W = 6;
    localparam logic [DEF_SIG_W-1:0] DEF_POLY  = 6'b110000;
    localparam logic [DEF_SIG_W-1:0] DEF_SEED  = 6'b000001;

    // Bit 0 takes the parity of the tapped bits plus din[0]. Every other bit
    // shifts up from its neighbour and absorbs its own din bit. Zero-extended
    // din bits contribute nothing.
    function automatic logic [DEF_SIG_W-1:0] misr_next(
        input logic [DEF_SIG_W-1:0] sig,
        input logic [DEF_SIG_W-1:0] din,
        input logic [DEF_SIG_W-1:0] poly
    );
        logic [DEF_SIG_W-1:0] nxt;
        nxt    = {DEF_SIG_W{1'b0}};
        nxt[0] = (^(sig & poly)) ^ din[0];
        for (int i = 1; i < DEF_SIG_W; i++) begin
            nxt[i] = sig[i-1] ^ din[i];
        end
        return nxt;
    endfunction

endpackage

// File: rtl/eqed_misr.sv
// eqed_misr: multiple-input signature register.
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (register returns to SEED)
//   load   in   reload SEED (takes priority over en)
//   en     in   compact din into the signature this cycle
//   din    in   [DIN_W-1:0] observed bits
//   sig    out  [SIG_W-1:0] current signature
module eqed_misr
    import eqed_chk_pkg::*;
#(
    parameter int               SIG_W = DEF_SIG_W,
    parameter int               DIN_W = 3,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [DIN_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] din_ext_s;
    logic [SIG_W-1:0] sig_nxt_s;
    logic [SIG_W-1:0] sig_r;

    // Zero-extend din so the upper MISR bits see no input.
    always_comb begin
        din_ext_s              = {SIG_W{1'b0}};
        din_ext_s[DIN_W-1:0]   = din;
    end

    // Next signature: seed on load, one compaction step on en, else hold.
    always_comb begin
        sig_nxt_s = sig_r;
        if (load) begin
            sig_nxt_s = SEED;
        end else if (en) begin
            sig_nxt_s = misr_next(sig_r, din_ext_s, POLY);
        end else begin
            sig_nxt_s = sig_r;
        end
    end

    // Signature register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_r <= SEED;
        end else begin
            sig_r <= sig_nxt_s;
        end
    end

    assign sig = sig_r;

endmodule

// File: rtl/eqed_sig_checker.sv
// eqed_sig_checker: compacts DUT outputs over a fixed window into a MISR
// signature. A golden run (mode=0) stores the reference; a check run (mode=1)
// compares against it to tell whether an injected bit flip became visible.
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a run (accepted only in IDLE)
//   mode         in   0 = capture golden, 1 = check (latched on start)
//   din          in   [DIN_W-1:0] observed DUT outputs
//   busy         out  high in RUN and DONE
//   done         out  one-cycle pulse at end of run
//   match        out  valid with done: check signature equals golden
//   no_golden    out  valid with done: check issued with no golden stored
//   sig          out  [SIG_W-1:0] current signature
//   golden       out  [SIG_W-1:0] stored reference signature
//   mismatch_cnt out  [7:0] saturating count of failed checks
//                     (only with EQED_SIG_CHECKER_MISMATCH_CNT_EN defined)
module eqed_sig_checker
    import eqed_chk_pkg::*;
#(
    parameter int               DIN_W  = 3,
    parameter int               SIG_W  = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY   = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED   = DEF_SEED,
    parameter int               WINDOW = 5,
    parameter int               CNT_W  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [DIN_W-1:0] din,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic             no_golden,
    output logic [SIG_W-1:0] sig,
    output logic [SIG_W-1:0] golden
`ifdef EQED_SIG_CHECKER_MISMATCH_CNT_EN
    ,
    output logic [7:0]       mismatch_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

    state_e           state_r;
    state_e           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             mode_r;
    logic [SIG_W-1:0] golden_r;
    logic             golden_valid_r;
    logic             accept_s;
    logic             run_s;
    logic             in_done_s;
    logic [SIG_W-1:0] sig_s;

    assign accept_s  = (state_r == IDLE) && start;
    assign run_s     = (state_r == RUN);
    assign in_done_s = (state_r == DONE);

    eqed_misr #(
        .SIG_W (SIG_W),
        .DIN_W (DIN_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept_s),
        .en    (run_s),
        .din   (din),
        .sig   (sig_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: RUN lasts exactly WINDOW cycles, DONE exactly one.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Window counter and latched mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CNT_W{1'b0}};
            mode_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r  <= {CNT_W{1'b0}};
            mode_r <= mode;
        end else if (run_s) begin
            cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Golden store: written only at the end of a capture run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            golden_r       <= {SIG_W{1'b0}};
            golden_valid_r <= 1'b0;
        end else if (in_done_s && !mode_r) begin
            golden_r       <= sig_s;
            golden_valid_r <= 1'b1;
        end
    end

`ifdef EQED_SIG_CHECKER_MISMATCH_CNT_EN
    logic [7:0] mismatch_cnt_r;

    // Saturating count of checks that saw a signature differing from golden.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_cnt_r <= 8'h00;
        end else if (in_done_s && mode_r && golden_valid_r &&
                     (sig_s != golden_r) && (mismatch_cnt_r != 8'hFF)) begin
            mismatch_cnt_r <= mismatch_cnt_r + 8'h01;
        end
    end

    assign mismatch_cnt = mismatch_cnt_r;
`endif

    // Status decoded from registered state; the verdicts exist only in DONE.
    always_comb begin
        busy      = (state_r != IDLE);
        done      = in_done_s;
        match     = 1'b0;
        no_golden = 1'b0;
        if (in_done_s && mode_r) begin
            match     = (sig_s == golden_r) && golden_valid_r;
            no_golden = !golden_valid_r;
        end else begin
            match     = 1'b0;
            no_golden = 1'b0;
        end
    end

    assign sig    = sig_s;
    assign golden = golden_r;

endmodule
